sample_error_unit: RTL and testbench

Per-sample loss stage that sits directly upstream of the epoch/validation bookkeeping block. It accepts one network output vector and its target vector per sample, walks the elements serially, and accumulates either absolute or squared error. It then emits a single saturated 16-bit error word with a one-cycle S_Error strobe. The downstream block sums that word into its epoch error whenever its VC is high.

---
 rtl/nn_pkg.sv | 26 ++
 rtl/err_term.sv | 29 ++
 rtl/sample_error_unit.sv | 147 ++++++++++++++
 tb/tb_sample_error_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// nn_pkg: shared types and constants for the per-sample error path.
//   DW/FRAC   : Q8.8 element format and the product shift in squared mode
//   ERR_MAX   : saturation ceiling of the reported error word
//   state_e   : sample_error_unit FSM states
//   elem_slice: pick element idx out of a packed vector (up to MAX_OUT elements)
package nn_pkg;

  localparam int DW      = 16;
  localparam int FRAC    = 8;
  localparam int MAX_OUT = 64;

  // Matches the downstream min-error seed, so a clipped sample is never an improvement.
  localparam logic [15:0] ERR_MAX = 16'h7FFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic [DW-1:0] elem_slice(input logic [MAX_OUT*DW-1:0] vec,
                                               input logic [5:0]            idx);
    return vec[idx*DW +: DW];
  endfunction

endpackage

// File: rtl/err_term.sv
// err_term: combinational per-element error term.
//   y, t    : signed Q8.8 output and target element
//   term    : MODE_SQ=0 -> |y-t|, MODE_SQ=1 -> ((y-t)^2) >> FRAC, unsigned
module err_term
  import nn_pkg::*;
#(
  parameter bit MODE_SQ = 1'b1
) (
  input  logic [DW-1:0]         y,
  input  logic [DW-1:0]         t,
  output logic [2*(DW+1)-1:0]   term
);

  logic signed [DW:0]         diff;
  logic        [DW:0]         abs_diff;
  logic signed [2*(DW+1)-1:0] sq;

  always_comb begin
    // One extra bit keeps the difference exact for any pair of DW-bit inputs.
    diff     = $signed({y[DW-1], y}) - $signed({t[DW-1], t});
    abs_diff = diff[DW] ? $unsigned(-diff) : $unsigned(diff);
    sq       = diff * diff;
    if (MODE_SQ)
      term = $unsigned(sq) >> FRAC;
    else
      term = {{(DW+1){1'b0}}, abs_diff};
  end

endmodule

// File: rtl/sample_error_unit.sv
// sample_error_unit: serial per-sample loss (sum of |e| or e^2) with saturated output.
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/ready  : sample handshake; ready only in IDLE
//   y_vec, t_vec    : N_OUT packed Q8.8 outputs / targets, element i at [i*DW +: DW]
//   error, sat      : saturated 16-bit sample error and clip flag, held between strobes
//   S_Error         : one-cycle strobe marking a new error/sat
//   busy            : high in ACCUM or DONE
//
// state | meaning
// IDLE  | waiting for a sample, in_ready=1
// ACCUM | adding one element term per cycle
// DONE  | clipping acc into error/sat, strobe issued on exit
module sample_error_unit
  import nn_pkg::*;
#(
  parameter int N_OUT   = 4,
  parameter bit MODE_SQ = 1'b1,
  parameter int ACC_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_OUT*DW-1:0]   y_vec,
  input  logic [N_OUT*DW-1:0]   t_vec,
  output logic [15:0]           error,
  output logic                  S_Error,
  output logic                  busy,
  output logic                  sat
);

  localparam int TW = 2*(DW+1);
  localparam int SW = ((ACC_W > TW) ? ACC_W : TW) + 1;

  state_e                state_q, state_d;
  logic [N_OUT*DW-1:0]   y_q, y_d, t_q, t_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [5:0]            idx_q, idx_d;
  logic [15:0]           error_q, error_d;
  logic                  sat_q, sat_d;
  logic                  strobe_q, strobe_d;
  logic                  in_ready_q, in_ready_d;
  logic                  busy_q, busy_d;

  logic [MAX_OUT*DW-1:0] y_pad, t_pad;
  logic [DW-1:0]         y_elem, t_elem;
  logic [TW-1:0]         term;
  logic [SW-1:0]         sum;

  always_comb begin
    y_pad = '0;
    t_pad = '0;
    y_pad[N_OUT*DW-1:0] = y_q;
    t_pad[N_OUT*DW-1:0] = t_q;
    y_elem = elem_slice(y_pad, idx_q);
    t_elem = elem_slice(t_pad, idx_q);
  end

  err_term #(.MODE_SQ(MODE_SQ)) u_err_term (
    .y    (y_elem),
    .t    (t_elem),
    .term (term)
  );

  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    t_d      = t_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    error_d  = error_q;
    sat_d    = sat_q;
    strobe_d = 1'b0;
    sum      = SW'(acc_q) + SW'(term);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          y_d     = y_vec;
          t_d     = t_vec;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        // Accumulator sticks at all-ones rather than wrapping.
        if (sum > SW'({ACC_W{1'b1}}))
          acc_d = '1;
        else
          acc_d = sum[ACC_W-1:0];
        idx_d = 6'(idx_q + 6'd1);
        if (idx_q == 6'(N_OUT-1))
          state_d = DONE;
      end
      DONE: begin
        if (acc_q > ACC_W'(ERR_MAX)) begin
          error_d = ERR_MAX;
          sat_d   = 1'b1;
        end else begin
          error_d = acc_q[15:0];
          sat_d   = 1'b0;
        end
        strobe_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Handshake flags follow the next state so they stay registered.
    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      y_q        <= '0;
      t_q        <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      error_q    <= '0;
      sat_q      <= 1'b0;
      strobe_q   <= 1'b0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      y_q        <= y_d;
      t_q        <= t_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      error_q    <= error_d;
      sat_q      <= sat_d;
      strobe_q   <= strobe_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign error    = error_q;
  assign sat      = sat_q;
  assign S_Error  = strobe_q;

endmodule

// File: tb/tb_sample_error_unit.sv
// Scoreboard bench for sample_error_unit with N_OUT=4: one instance per mode
// (absolute and squared) driven by the same stimulus.
module tb_sample_error_unit;

  localparam int N_OUT = 4;

  typedef struct {
    logic [15:0] e0;
    logic        s0;
    logic [15:0] e1;
    logic        s1;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] y_vec, t_vec;

  logic        in_ready0, S_Error0, busy0, sat0;
  logic [15:0] error0;
  logic        in_ready1, S_Error1, busy1, sat1;
  logic [15:0] error1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_accepts = 0;
  int n_strobes = 0;

  exp_t cur_exp;
  exp_t q[$];

  // timing model of the DUT
  int          m_cnt = 0;
  logic        m_strobe = 1'b0;
  logic [15:0] m_err0 = '0, m_err1 = '0;
  logic        m_sat0 = 1'b0, m_sat1 = 1'b0;

  always #5 clk = ~clk;

  sample_error_unit #(.N_OUT(N_OUT), .MODE_SQ(1'b0), .ACC_W(32)) u_abs (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .y_vec(y_vec), .t_vec(t_vec), .error(error0), .S_Error(S_Error0),
    .busy(busy0), .sat(sat0)
  );

  sample_error_unit #(.N_OUT(N_OUT), .MODE_SQ(1'b1), .ACC_W(32)) u_sq (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .y_vec(y_vec), .t_vec(t_vec), .error(error1), .S_Error(S_Error1),
    .busy(busy1), .sat(sat1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model(input logic [63:0] y, input logic [63:0] t, input bit sq,
                                output logic [15:0] e, output logic s);
    longint acc;
    longint d;
    acc = 0;
    for (int i = 0; i < N_OUT; i++) begin
      d = longint'($signed(y[i*16 +: 16])) - longint'($signed(t[i*16 +: 16]));
      if (sq) acc += (d * d) >>> 8;
      else    acc += (d < 0) ? -d : d;
    end
    s = (acc > 32767);
    e = s ? 16'h7FFF : acc[15:0];
  endfunction

  // monitor: compare DUT outputs against the model, then advance the model
  initial begin
    exp_t e;
    logic exp_ready;
    @(posedge clk);
    #1;
    forever begin
      @(negedge clk);
      cyc++;
      exp_ready = (m_cnt == 0);
      chk("in_ready_abs", 32'(in_ready0), 32'(exp_ready));
      chk("in_ready_sq",  32'(in_ready1), 32'(exp_ready));
      chk("busy_abs",     32'(busy0),     32'(!exp_ready));
      chk("busy_sq",      32'(busy1),     32'(!exp_ready));
      chk("strobe_abs",   32'(S_Error0),  32'(m_strobe));
      chk("strobe_sq",    32'(S_Error1),  32'(m_strobe));
      chk("error_abs",    32'(error0),    32'(m_err0));
      chk("error_sq",     32'(error1),    32'(m_err1));
      chk("sat_abs",      32'(sat0),      32'(m_sat0));
      chk("sat_sq",       32'(sat1),      32'(m_sat1));
      if (S_Error0 === 1'b1) n_strobes++;

      if (rst) begin
        n_accepts -= q.size();
        q.delete();
        m_cnt = 0; m_strobe = 1'b0;
        m_err0 = '0; m_err1 = '0; m_sat0 = 1'b0; m_sat1 = 1'b0;
      end else begin
        m_strobe = 1'b0;
        if (m_cnt == 1) begin
          if (q.size() > 0) begin
            e = q.pop_front();
            m_err0 = e.e0; m_sat0 = e.s0; m_err1 = e.e1; m_sat1 = e.s1;
            m_strobe = 1'b1;
          end
          m_cnt = 0;
        end else if (m_cnt > 1) begin
          m_cnt--;
        end else if (in_valid) begin
          q.push_back(cur_exp);
          n_accepts++;
          m_cnt = N_OUT + 1;
        end
      end
    end
  end

  // caller is at posedge+1; vectors are scrambled after the accept edge
  task automatic send(input logic [63:0] y, input logic [63:0] t,
                      input logic [15:0] e0, input logic s0,
                      input logic [15:0] e1, input logic s1);
    int n;
    n = 0;
    y_vec = y; t_vec = t;
    cur_exp = '{e0, s0, e1, s1};
    in_valid = 1'b1;
    while (in_ready0 !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("send_timeout", 32'(n < 20), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      y_vec = {$urandom, $urandom};
      t_vec = {$urandom, $urandom};
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [15:0] me0, me1;
    logic        ms0, ms1;
    rst = 1'b1; in_valid = 1'b0; y_vec = '0; t_vec = '0;
    cur_exp = '{16'h0, 1'b0, 16'h0, 1'b0};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // directed vectors, hand-computed (element 0 in the low bits)
    send({4{16'h0200}}, {4{16'h0000}}, 16'h0800, 1'b0, 16'h1000, 1'b0);
    send({4{16'h0000}}, {4{16'h0100}}, 16'h0400, 1'b0, 16'h0400, 1'b0);
    send({4{16'h7FFF}}, {4{16'h8000}}, 16'h7FFF, 1'b1, 16'h7FFF, 1'b1);
    send({4{16'h1234}}, {4{16'h1234}}, 16'h0000, 1'b0, 16'h0000, 1'b0);
    send({16'h0000, 16'h0080, 16'hFF00, 16'h0100},
         {16'h0300, 16'h0000, 16'h0000, 16'h0000}, 16'h0580, 1'b0, 16'h0B40, 1'b0);
    send({16'h1FFF, 16'h2000, 16'h2000, 16'h2000}, {4{16'h0000}}, 16'h7FFF, 1'b0, 16'h7FFF, 1'b1);
    send({4{16'h2000}}, {4{16'h0000}}, 16'h7FFF, 1'b1, 16'h7FFF, 1'b1);
    send({4{16'h0001}}, {4{16'h0000}}, 16'h0004, 1'b0, 16'h0000, 1'b0);

    // reset on the second ACCUM cycle aborts the sample
    y_vec = {4{16'h0200}}; t_vec = '0;
    cur_exp = '{16'h0800, 1'b0, 16'h1000, 1'b0};
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) begin @(posedge clk); #1; end

    // reset and in_valid together: reset wins
    rst = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    send({4{16'hFF00}}, {4{16'h0100}}, 16'h0800, 1'b0, 16'h1000, 1'b0);

    // in_valid held high with data changing every cycle
    in_valid = 1'b1;
    for (int k = 0; k < 32; k++) begin
      y_vec = {$urandom, $urandom};
      t_vec = {$urandom, $urandom};
      if (k % 3 == 0) t_vec = y_vec ^ {4{16'h0011}};
      model(y_vec, t_vec, 1'b0, me0, ms0);
      model(y_vec, t_vec, 1'b1, me1, ms1);
      cur_exp = '{me0, ms0, me1, ms1};
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end

    chk("queue_empty", 32'(q.size()), 32'd0);
    chk("strobes_vs_accepts", 32'(n_strobes), 32'(n_accepts));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
